// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative MULT/MULTU/DIV/DIVU sequencer for the EX stage.
// It runs a radix-2 shift-add multiply or a restoring divide, one bit per cycle,
// and takes WIDTH+1 cycles from accept to done. A divide by zero takes one cycle.
// While the loop runs it holds the pipeline through stallreq.
// It writes HI/LO with a one-cycle done/whi/wlo pulse. A flush drops the operation.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   start, op_sel - request and opcode (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   opa, opb      - rs / rt operands, sampled only in the accept cycle
//   flush         - abort; no HI/LO write follows
//   busy, stallreq, done, whi, wlo - status / write enables
//   wHiData, wLoData - results, held between writes
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op_sel,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             flush,
  output logic             busy,
  output logic             stallreq,
  output logic             done,
  output logic             whi,
  output logic             wlo,
  output logic [WIDTH-1:0] wHiData,
  output logic [WIDTH-1:0] wLoData
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t             state_q, state_d;
  logic               div_q, div_d;
  logic               sgnq_q, sgnq_d;   // sign of quotient / product
  logic               sgnr_q, sgnr_d;   // sign of remainder (dividend sign)
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   b_q, b_d;         // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc_q, acc_d;     // mult: {hi, multiplier}; div: low half = dividend/quotient
  logic [WIDTH-1:0]   rem_q, rem_d;     // partial remainder (always < divisor)
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               in_div, in_signed;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     add_sum;
  logic [2*WIDTH-1:0] mul_next, prod_fix;
  logic [WIDTH:0]     shl;              // shifted partial remainder needs one extra bit
  logic               ge;
  logic [WIDTH-1:0]   rem_next, quo_next, quo_fix, rem_fix;

  assign in_div    = op_sel[1];
  assign in_signed = ~op_sel[0];
  assign abs_a     = (in_signed && opa[WIDTH-1]) ? -opa : opa;
  assign abs_b     = (in_signed && opb[WIDTH-1]) ? -opb : opb;

  // Multiply step: conditionally add multiplicand to the high half, then shift
  // the whole accumulator right, keeping the carry as the new top bit.
  assign add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign mul_next = {add_sum, acc_q[WIDTH-1:1]};
  assign prod_fix = sgnq_q ? -mul_next : mul_next;

  // Restoring divide step: shift in the next dividend bit, subtract if it fits.
  assign shl      = {rem_q, acc_q[WIDTH-1]};
  assign ge       = (shl >= {1'b0, b_q});
  assign rem_next = ge ? WIDTH'(shl - {1'b0, b_q}) : shl[WIDTH-1:0];
  assign quo_next = {acc_q[WIDTH-2:0], ge};
  assign quo_fix  = sgnq_q ? -quo_next : quo_next;
  assign rem_fix  = sgnr_q ? -rem_next : rem_next;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    sgnq_d  = sgnq_q;
    sgnr_d  = sgnr_q;
    cnt_d   = cnt_q;
    b_d     = b_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    busy     = (state_q == S_CALC);
    stallreq = (state_q == S_CALC) || ((state_q == S_IDLE) && start && !flush);
    done     = (state_q == S_DONE) && !flush;
    whi      = done;
    wlo      = done;

    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          div_d  = in_div;
          sgnq_d = in_signed && (opa[WIDTH-1] ^ opb[WIDTH-1]);
          sgnr_d = in_signed && opa[WIDTH-1];
          cnt_d  = '0;
          rem_d  = '0;
          if (in_div) begin
            b_d   = abs_b;
            acc_d = {{WIDTH{1'b0}}, abs_a};
          end else begin
            b_d   = abs_a;
            acc_d = {{WIDTH{1'b0}}, abs_b};
          end
          if (in_div && (opb == '0)) begin
            // Divide by zero: skip the loop, HI gets the raw dividend.
            hi_d    = opa;
            lo_d    = '1;
            state_d = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (div_q) begin
            acc_d[WIDTH-1:0] = quo_next;
            rem_d            = rem_next;
          end else begin
            acc_d = mul_next;
          end
          if (cnt_q == CW'(WIDTH - 1)) begin
            // Final iteration: register the sign-corrected result for DONE.
            state_d = S_DONE;
            if (div_q) begin
              hi_d = rem_fix;
              lo_d = quo_fix;
            end else begin
              hi_d = prod_fix[2*WIDTH-1:WIDTH];
              lo_d = prod_fix[WIDTH-1:0];
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      div_q   <= 1'b0;
      sgnq_q  <= 1'b0;
      sgnr_q  <= 1'b0;
      cnt_q   <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      sgnq_q  <= sgnq_d;
      sgnr_q  <= sgnr_d;
      cnt_q   <= cnt_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign wHiData = hi_q;
  assign wLoData = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed-vector bench for muldiv_seq.
// Inputs are driven and outputs are sampled on the falling edge.
// Expected results are hand-computed constants.
module tb_muldiv_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, flush;
  logic [1:0]   op_sel;
  logic [W-1:0] opa, opb;
  logic         busy, stallreq, done, whi, wlo;
  logic [W-1:0] wHiData, wLoData;

  int n_cmp = 0;
  int n_bad = 0;

  muldiv_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op_sel(op_sel), .opa(opa), .opb(opb),
    .flush(flush), .busy(busy), .stallreq(stallreq), .done(done), .whi(whi),
    .wlo(wlo), .wHiData(wHiData), .wLoData(wLoData)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Called in an IDLE cycle at the falling edge. It issues one op and waits for done.
  // A second start is poked during CALC at cycle 'poke' (0 = none).
  // The task returns at the falling edge of the cycle after done.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int poke, input logic [W-1:0] exp_hi,
                        input logic [W-1:0] exp_lo, input int exp_lat);
    int cyc, stalls;
    bit seen;
    chk({tag, "_idle_done"}, done, 1'b0);
    op_sel = op; opa = a; opb = b; start = 1'b1;
    #1;
    chk({tag, "_stall_T"}, stallreq, 1'b1);
    @(negedge clk);
    start = 1'b0; op_sel = ~op; opa = 32'hDEAD_BEEF; opb = 32'h0;
    cyc = 1; stalls = 0; seen = 1'b0;
    while (cyc <= 60 && !seen) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (stallreq) stalls++;
        if (cyc == poke) begin
          start = 1'b1; op_sel = 2'b01; opa = 32'd7; opb = 32'd7;
        end
        @(negedge clk);
        start = 1'b0;
        cyc++;
      end
    end
    chk({tag, "_latency"}, seen ? cyc : -1, exp_lat);
    chk({tag, "_stall_cycles"}, stalls, exp_lat - 1);
    chk({tag, "_hi"}, wHiData, exp_hi);
    chk({tag, "_lo"}, wLoData, exp_lo);
    chk({tag, "_whi_wlo"}, {whi, wlo}, 2'b11);
    chk({tag, "_stall_done"}, {stallreq, busy}, 2'b00);
    @(negedge clk);
  endtask

  // Count done pulses over n cycles; none are expected.
  task automatic no_write(input string tag, input int n);
    int pulses;
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      if (done || whi || wlo) pulses++;
      @(negedge clk);
    end
    chk({tag, "_no_write"}, pulses, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; op_sel = 2'b00; opa = '0; opb = '0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {done, whi, wlo, busy, stallreq}, 5'b0);
    chk("rst_hi", wHiData, 0);
    chk("rst_lo", wLoData, 0);
    rst = 1'b0;
    @(negedge clk);

    // Consecutive run_op calls issue start in the cycle right after DONE.
    run_op("mult",     2'b00, 32'hFFFF_FFFD, 32'd5,         0, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 33);
    run_op("multu",    2'b01, 32'hFFFF_FFFD, 32'd5,         0, 32'h0000_0004, 32'hFFFF_FFF1, 33);
    run_op("divu",     2'b11, 32'd100,       32'd7,         0, 32'd2,         32'hE,         33);
    run_op("div_neg",  2'b10, 32'hFFFF_FFF9, 32'd2,         0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    run_op("div_ovf",  2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h0,         32'h8000_0000, 33);
    run_op("div_posr", 2'b10, 32'd7,         32'hFFFF_FFFE, 0, 32'd1,         32'hFFFF_FFFD, 33);
    run_op("mult_m1",  2'b00, 32'd7,         32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 33);
    run_op("div_by0",  2'b10, 32'h1234,      32'h0,         0, 32'h1234,      32'hFFFF_FFFF, 1);
    run_op("divu_by0", 2'b11, 32'h8765_4321, 32'h0,         0, 32'h8765_4321, 32'hFFFF_FFFF, 1);
    run_op("multu_pk", 2'b01, 32'h0001_0000, 32'h0001_0000, 5, 32'h1,         32'h0,         33);
    no_write("poke", 40);

    // Flush at T+10 drops the multiply.
    op_sel = 2'b00; opa = 32'd3; opb = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush_done_forced", done, 1'b0);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_idle", {busy, stallreq}, 2'b00);
    no_write("flush", 40);
    run_op("divu_after_flush", 2'b11, 32'd9, 32'd2, 0, 32'd1, 32'd4, 33);

    // Reset at T+20 aborts the multiply and clears the held results.
    op_sel = 2'b01; opa = 32'd3; opb = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_ctrl", {done, whi, wlo, busy, stallreq}, 5'b0);
    chk("midrst_hi", wHiData, 0);
    chk("midrst_lo", wLoData, 0);
    no_write("midrst", 40);
    run_op("multu_after_rst", 2'b01, 32'd6, 32'd7, 0, 32'd0, 32'h2A, 33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative multiply/divide sequencer for the EX stage. Replaces the single-cycle combinational mult/div datapath.
- Accepts one MULT/MULTU/DIV/DIVU operation and runs a radix-2 shift-add or restoring-divide loop over WIDTH cycles.
- Holds the pipeline through stallreq while the loop runs.
- Delivers a one-cycle HI/LO write pulse on completion.
- Drops the operation on a pipeline flush (exception, eret).

Parameters:
WIDTH, 32, operand width. Also the number of iteration cycles.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset; synchronous, active-high
start  in  1  request a new operation; sampled only in IDLE
op_sel  in  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
opa  in  WIDTH  multiplicand / dividend (rs)
opb  in  WIDTH  multiplier / divisor (rt)
flush  in  1  abort the current operation; no HI/LO write follows
busy  out  1  high in CALC state
stallreq  out  1  pipeline stall request to the control unit
done  out  1  one-cycle pulse; result valid
whi  out  1  HI write enable; equals done
wlo  out  1  LO write enable; equals done
wHiData  out  WIDTH  HI result (product high half / remainder)
wLoData  out  WIDTH  LO result (product low half / quotient)

Behaviour:
- States: IDLE, CALC, DONE. Encoding is free.
- Reset (rst=1 at the clock edge):
  - state goes to IDLE; counter = 0; all internal registers cleared.
  - done=0, whi=0, wlo=0, busy=0; wHiData and wLoData = 0.
  - Reset has priority over flush and start, and aborts any operation in progress with no write.
- stallreq is combinational: (state==IDLE & start & !flush) | state==CALC. It is 0 in DONE, so the instruction advances in the cycle the result is written.
- IDLE, start=1, flush=0 at edge T:
  - latch op_sel.
  - For signed ops, latch absolute values of opa and opb, sign_q = opa[MSB]^opb[MSB] and sign_r = opa[MSB]. Unsigned ops latch the raw operands and both sign flags are 0.
  - counter = 0.
  - For a division with opb==0, go to DONE. Otherwise go to CALC.
- CALC, one iteration per cycle:
  - Multiply: shift-add over a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract. The partial remainder is WIDTH+1 bits.
  - counter increments each cycle. After the WIDTH-th iteration (counter==WIDTH-1 at the edge), go to DONE.
  - Latency: done is high in cycle T+WIDTH+1, i.e. T+33 for WIDTH=32.
- DONE, for exactly one cycle:
  - done=1, whi=1, wlo=1, and wHiData/wLoData are driven.
  - Next state is IDLE. A start seen in DONE is ignored; the requester re-presents it in IDLE.
- Sign fix, applied when results are driven:
  - Signed multiply: 2*WIDTH product negated (two's complement) if sign_q=1.
  - Signed divide: quotient negated if sign_q=1; remainder negated if sign_r=1.
  - -2^(W-1) / -1 yields quotient 0x8000_0000 and remainder 0, with natural wrap and no trap.
- Divide by zero (DIV or DIVU with opb==0):
  - no iterations; done is high at T+1.
  - wHiData = opa as presented (unmodified).
  - wLoData = all ones.
- flush:
  - In CALC or DONE: next state IDLE, done/whi/wlo forced 0 in that same cycle, no write.
  - In IDLE with start: the start is ignored.
- start while in CALC is ignored. Operand inputs are don't-care outside the IDLE accept cycle.
- wHiData and wLoData hold their last values outside DONE. Consumers qualify them with whi/wlo.

Test Plan:
- MULT opa=0xFFFF_FFFD (-3), opb=5, start at T -> stallreq high T..T+32, done at T+33 with HI=0xFFFF_FFFF, LO=0xFFFF_FFF1; MULTU of the same operands -> HI=0x0000_0004, LO=0xFFFF_FFF1.
- DIVU 100/7 -> HI=2, LO=0xE at T+33; DIV 0xFFFF_FFF9 (-7)/2 -> LO=0xFFFF_FFFD, HI=0xFFFF_FFFF; DIV 0x8000_0000/0xFFFF_FFFF -> LO=0x8000_0000, HI=0.
- DIV 0x1234/0 -> done at T+1, HI=0x1234, LO=0xFFFF_FFFF, stallreq high only in cycle T.
- start MULT, flush at T+10 -> IDLE at T+11, no whi/wlo pulse ever; a new DIVU 9/2 issued in IDLE completes normally (HI=1, LO=4).
- second start at T+5 during CALC -> ignored, first result unchanged at T+33; rst=1 at T+20 -> next cycle all outputs 0, IDLE, no write.
- back-to-back: start in the cycle after DONE -> accepted; results of both operations correct; done pulses are exactly one cycle each.
